// File: rtl/msrv32_dmem_if_pkg.sv
// Shared definitions for the msrv32 data-memory interface: FSM states, access
// sizes, default timeout and the store lane helpers.
package msrv32_dmem_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RWAIT = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  // Size 2'b11 falls through to the word case.
  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  store_mask = 4'b0001 << addr_lo;
      SIZE_H:  store_mask = 4'b0011 << {addr_lo[1], 1'b0};
      default: store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_B:  store_data = {4{data[7:0]}};
      SIZE_H:  store_data = {2{data[15:0]}};
      default: store_data = data;
    endcase
  endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Load lane select and sign/zero extension; purely combinational.
module msrv32_load_align
  import msrv32_dmem_if_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      SIZE_B:  data_o = unsigned_i ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SIZE_H:  data_o = unsigned_i ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/msrv32_dmem_if.sv
// Core-side load/store unit to a simple req/gnt/rvalid data bus, with a
// per-access timeout that converts a hung bus into a one-cycle error strobe.
module msrv32_dmem_if
  import msrv32_dmem_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        mem_wr_req_in,
  input  logic        mem_rd_req_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wr_data_in,
  input  logic [1:0]  size_in,
  input  logic        load_unsigned_in,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        bus_err_out,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wmask_out,
  input  logic        dmem_gnt_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rdata_in,
  input  logic        dmem_err_in
);

  // The counter starts at 0 on the first REQ cycle, so the access is abandoned
  // at the end of the TIMEOUT_CYCLES-th bus cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] wdata_d;
  logic [3:0]  wmask_q;
  logic [3:0]  wmask_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] load_data_q;
  logic [31:0] load_data_d;
  logic        load_valid_q;
  logic        bus_err_q;
  logic        any_req;
  logic        timeout;

  assign any_req = mem_wr_req_in | mem_rd_req_in;
  assign cnt_d   = cnt_q + 8'd1;
  assign timeout = (cnt_q == CNT_LAST);
  assign wmask_d = mem_wr_req_in ? store_mask(size_in, addr_in[1:0]) : 4'b0000;
  assign wdata_d = mem_wr_req_in ? store_data(size_in, wr_data_in) : 32'b0;

  msrv32_load_align u_load_align (
    .rdata_i    (dmem_rdata_in),
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data_d)
  );

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      addr_q       <= 32'b0;
      wdata_q      <= 32'b0;
      wmask_q      <= 4'b0;
      we_q         <= 1'b0;
      size_q       <= 2'b0;
      uns_q        <= 1'b0;
      load_data_q  <= 32'b0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A write wins over a simultaneous read via we_q and wmask_d.
          if (any_req) begin
            addr_q  <= addr_in;
            we_q    <= mem_wr_req_in;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            size_q  <= size_in;
            uns_q   <= load_unsigned_in;
            cnt_q   <= 8'd0;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_d;
          if (dmem_gnt_in) begin
            if (we_q) begin
              bus_err_q <= dmem_err_in;
              state_q   <= ST_IDLE;
            end else begin
              state_q <= ST_RWAIT;
            end
          end else if (timeout) begin
            bus_err_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        ST_RWAIT: begin
          cnt_q <= cnt_d;
          if (dmem_rvalid_in) begin
            load_data_q  <= load_data_d;
            load_valid_q <= ~dmem_err_in;
            bus_err_q    <= dmem_err_in;
            state_q      <= ST_IDLE;
          end else if (timeout) begin
            bus_err_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Gated by reset so the core sees no stall while the block is held in reset.
  assign stall_out      = ~ms_riscv32_mp_rst_in & ((state_q != ST_IDLE) | any_req);
  assign dmem_req_out   = (state_q == ST_REQ);
  assign dmem_we_out    = we_q;
  assign dmem_addr_out  = {addr_q[31:2], 2'b00};
  assign dmem_wdata_out = wdata_q;
  assign dmem_wmask_out = wmask_q;
  assign load_data_out  = load_data_q;
  assign load_valid_out = load_valid_q;
  assign bus_err_out    = bus_err_q;

endmodule

// File: tb/tb_msrv32_dmem_if.sv
// Directed bench for msrv32_dmem_if: expected load/error completions are queued
// when an access is issued and checked when the DUT raises a strobe.
module tb_msrv32_dmem_if;
  import msrv32_dmem_if_pkg::*;

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        wr_req;
  logic        rd_req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        uns;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   stall_cnt;
  logic cnt_en;

  msrv32_dmem_if #(.TIMEOUT_CYCLES(4)) u_dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .mem_wr_req_in        (wr_req),
    .mem_rd_req_in        (rd_req),
    .addr_in              (addr),
    .wr_data_in           (wdata),
    .size_in              (size),
    .load_unsigned_in     (uns),
    .stall_out            (stall),
    .load_data_out        (load_data),
    .load_valid_out       (load_valid),
    .bus_err_out          (bus_err),
    .dmem_req_out         (dmem_req),
    .dmem_we_out          (dmem_we),
    .dmem_addr_out        (dmem_addr),
    .dmem_wdata_out       (dmem_wdata),
    .dmem_wmask_out       (dmem_wmask),
    .dmem_gnt_in          (gnt),
    .dmem_rvalid_in       (rvalid),
    .dmem_rdata_in        (rdata),
    .dmem_err_in          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!cnt_en) stall_cnt <= 0;
    else if (stall) stall_cnt <= stall_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {27'b0, stall, dmem_req, dmem_we, load_valid, bus_err}, 32'h0);
    chk({tag, "_mask"}, {28'b0, dmem_wmask}, 32'h0);
    chk({tag, "_addr"}, dmem_addr, 32'h0);
    chk({tag, "_wdata"}, dmem_wdata, 32'h0);
    chk({tag, "_ldata"}, load_data, 32'h0);
  endtask

  task automatic issue(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, input logic u);
    wr_req = wr; rd_req = rd; addr = a; wdata = d; size = sz; uns = u;
    #1;
    chk("stall_on_req", {31'b0, stall}, 32'h1);
    step();
    wr_req = 1'b0; rd_req = 1'b0;
    chk("req_after_capture", {31'b0, dmem_req}, 32'h1);
  endtask

  task automatic write_gnt(input logic e);
    gnt = 1'b1; err = e;
    step();
    gnt = 1'b0; err = 1'b0;
  endtask

  task automatic read_resp(input logic [31:0] rd, input logic e);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    chk("req_drop_rwait", {31'b0, dmem_req}, 32'h0);
    rvalid = 1'b1; rdata = rd; err = e;
    step();
    rvalid = 1'b0; err = 1'b0;
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, {30'b0, load_valid, bus_err}, 32'h0);
      step();
    end
  endtask

  task automatic collect(input string tag);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (load_valid || bus_err) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    total++;
    assert (seen) else begin
      bad++;
      $error("FAIL %s_strobe observed=none expected=strobe", tag);
    end
    if (seen && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_both"}, {31'b0, load_valid & bus_err}, 32'h0);
      chk({tag, "_err"}, {31'b0, bus_err}, {31'b0, e.is_err});
      chk({tag, "_valid"}, {31'b0, load_valid}, {31'b0, ~e.is_err});
      if (!e.is_err) chk({tag, "_data"}, load_data, e.data);
      step();
      chk({tag, "_pulse"}, {30'b0, load_valid, bus_err}, 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; addr = '0; wdata = '0; size = '0;
    uns = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; err = 1'b0; cnt_en = 1'b0;
    repeat (2) step();
    chk_zero("reset");
    rst = 1'b0;
    step();
    chk("idle_stall", {31'b0, stall}, 32'h0);

    // sb with grant in the second REQ cycle
    cnt_en = 1'b1;
    issue(1'b1, 1'b0, 32'h0000_1003, 32'h0000_00A5, SIZE_B, 1'b0);
    chk("sb_addr", dmem_addr, 32'h0000_1000);
    chk("sb_mask", {28'b0, dmem_wmask}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    chk("sb_we", {31'b0, dmem_we}, 32'h1);
    step();
    chk("sb_req_held", {31'b0, dmem_req}, 32'h1);
    chk("sb_addr_held", dmem_addr, 32'h0000_1000);
    write_gnt(1'b0);
    chk("sb_req_drop", {31'b0, dmem_req}, 32'h0);
    chk("sb_no_err", {31'b0, bus_err}, 32'h0);
    step();
    chk("sb_stall_cycles", stall_cnt, 32'd3);
    cnt_en = 1'b0;

    issue(1'b1, 1'b0, 32'h0000_3007, 32'h1234_BEEF, SIZE_H, 1'b0);
    chk("sh_addr", dmem_addr, 32'h0000_3004);
    chk("sh_mask", {28'b0, dmem_wmask}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    write_gnt(1'b0);

    issue(1'b1, 1'b0, 32'h0000_400B, 32'hCAFE_F00D, 2'b11, 1'b0);
    chk("sw_addr", dmem_addr, 32'h0000_4008);
    chk("sw_mask", {28'b0, dmem_wmask}, 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
    write_gnt(1'b0);

    sb_q.push_back('{is_err: 1'b0, data: 32'hFFFF_8001});
    issue(1'b0, 1'b1, 32'h0000_2002, 32'h0, SIZE_H, 1'b0);
    chk("lh_we", {31'b0, dmem_we}, 32'h0);
    chk("lh_mask", {28'b0, dmem_wmask}, 32'h0);
    chk("lh_addr", dmem_addr, 32'h0000_2000);
    read_resp(32'h8001_1234, 1'b0);
    collect("lh_s");

    sb_q.push_back('{is_err: 1'b0, data: 32'h0000_8001});
    issue(1'b0, 1'b1, 32'h0000_2002, 32'h0, SIZE_H, 1'b1);
    read_resp(32'h8001_5678, 1'b0);
    collect("lh_u");

    sb_q.push_back('{is_err: 1'b0, data: 32'h0000_0056});
    issue(1'b0, 1'b1, 32'h0000_5001, 32'h0, SIZE_B, 1'b0);
    read_resp(32'h1234_5678, 1'b0);
    collect("lb1_s");

    sb_q.push_back('{is_err: 1'b0, data: 32'hFFFF_FF9A});
    issue(1'b0, 1'b1, 32'h0000_5003, 32'h0, SIZE_B, 1'b0);
    read_resp(32'h9A34_5678, 1'b0);
    collect("lb3_s");

    sb_q.push_back('{is_err: 1'b0, data: 32'h0000_009A});
    issue(1'b0, 1'b1, 32'h0000_5003, 32'h0, SIZE_B, 1'b1);
    read_resp(32'h9A34_5678, 1'b0);
    collect("lb3_u");

    sb_q.push_back('{is_err: 1'b0, data: 32'hFFFF_FFF4});
    issue(1'b0, 1'b1, 32'h0000_5002, 32'h0, SIZE_B, 1'b0);
    read_resp(32'h12F4_5678, 1'b0);
    collect("lb2_s");

    sb_q.push_back('{is_err: 1'b0, data: 32'hDEAD_BEEF});
    issue(1'b0, 1'b1, 32'h0000_6002, 32'h0, SIZE_W, 1'b0);
    read_resp(32'hDEAD_BEEF, 1'b0);
    collect("lw");

    // simultaneous read and write: only the write goes out
    issue(1'b1, 1'b1, 32'h0000_7000, 32'h1122_3344, SIZE_W, 1'b0);
    chk("rdwr_we", {31'b0, dmem_we}, 32'h1);
    chk("rdwr_mask", {28'b0, dmem_wmask}, 32'hF);
    chk("rdwr_wdata", dmem_wdata, 32'h1122_3344);
    write_gnt(1'b0);
    chk("rdwr_idle", {31'b0, dmem_req}, 32'h0);
    quiet("rdwr_quiet", 2);

    sb_q.push_back('{is_err: 1'b1, data: 32'h0});
    issue(1'b1, 1'b0, 32'h0000_8000, 32'h0BAD_0BAD, SIZE_W, 1'b0);
    write_gnt(1'b1);
    collect("sw_err");

    sb_q.push_back('{is_err: 1'b1, data: 32'h0});
    issue(1'b0, 1'b1, 32'h0000_9000, 32'h0, SIZE_W, 1'b0);
    read_resp(32'h5555_5555, 1'b1);
    collect("lw_err");

    // timeout with grant never given
    sb_q.push_back('{is_err: 1'b1, data: 32'h0});
    issue(1'b0, 1'b1, 32'h0000_A000, 32'h0, SIZE_W, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_held", {31'b0, dmem_req}, 32'h1);
      step();
    end
    chk("to_req_drop", {31'b0, dmem_req}, 32'h0);
    collect("timeout");

    // request held while a completion strobe fires: taken once IDLE
    sb_q.push_back('{is_err: 1'b1, data: 32'h0});
    issue(1'b1, 1'b0, 32'h0000_B000, 32'h0000_0001, SIZE_W, 1'b0);
    gnt = 1'b1; err = 1'b1;
    wr_req = 1'b1; addr = 32'h0000_C004; wdata = 32'h0000_0002; size = SIZE_W;
    step();
    gnt = 1'b0; err = 1'b0;
    chk("b2b_idle", {31'b0, dmem_req}, 32'h0);
    collect("b2b_err");
    wr_req = 1'b0;
    chk("b2b_req2", {31'b0, dmem_req}, 32'h1);
    chk("b2b_addr2", dmem_addr, 32'h0000_C004);
    chk("b2b_wdata2", dmem_wdata, 32'h0000_0002);
    write_gnt(1'b0);

    // reset mid-REQ drops the request immediately
    issue(1'b1, 1'b0, 32'h0000_D000, 32'h1234_5678, SIZE_W, 1'b0);
    rst = 1'b1;
    #1;
    chk_zero("rst_in_req");
    step();
    rst = 1'b0;
    step();

    // reset in RWAIT, late rvalid must be ignored
    issue(1'b0, 1'b1, 32'h0000_E000, 32'h0, SIZE_W, 1'b0);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero("rst_in_rwait");
    step();
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'h7777_7777;
    step();
    rvalid = 1'b0;
    quiet("late_rvalid", 3);
    chk_zero("after_rst");

    sb_q.push_back('{is_err: 1'b0, data: 32'h0BAD_F00D});
    issue(1'b0, 1'b1, 32'h0000_F000, 32'h0, SIZE_W, 1'b0);
    chk("post_rst_addr", dmem_addr, 32'h0000_F000);
    read_resp(32'h0BAD_F00D, 1'b0);
    collect("post_rst_lw");

    chk("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msrv32_dmem_if.md
MSRV32_DMEM_IF -- requirements
Module: msrv32_dmem_if

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, setting the maximum bus cycles per access before an error is raised.
REQ-002 The block SHALL have these ports, one per line, as name, direction, width, meaning:
- ms_riscv32_mp_clk_in  in  1  sole clock, rising edge
- ms_riscv32_mp_rst_in  in  1  reset, asynchronous, active-high
- mem_wr_req_in  in  1  store request from the core
- mem_rd_req_in  in  1  load request from the core
- addr_in  in  32  byte address
- wr_data_in  in  32  store data, right-justified
- size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word
- load_unsigned_in  in  1  1 zero-extends loads, 0 sign-extends
- stall_out  out  1  core hold
- load_data_out  out  32  aligned, extended load result
- load_valid_out  out  1  one-cycle load completion strobe
- bus_err_out  out  1  one-cycle error strobe
- dmem_req_out  out  1  bus request
- dmem_we_out  out  1  1 write, 0 read
- dmem_addr_out  out  32  word address, bits [1:0] = 00
- dmem_wdata_out  out  32  lane-replicated store data
- dmem_wmask_out  out  4  byte enables
- dmem_gnt_in  in  1  bus accepts the request this cycle
- dmem_rvalid_in  in  1  read data valid
- dmem_rdata_in  in  32  read data
- dmem_err_in  in  1  bus error, qualified by dmem_gnt_in (writes) or dmem_rvalid_in (reads)

Function
REQ-003 The FSM SHALL have three states: IDLE, REQ, RWAIT.
REQ-004 In IDLE, a request SHALL be captured at the clock edge (addr, mask, wdata, we, size, unsigned), and the state SHALL go to REQ.
REQ-005 If mem_wr_req_in and mem_rd_req_in are both high, the write SHALL win.
REQ-006 stall_out SHALL equal (state != IDLE) OR (state == IDLE AND any request), combinationally.
REQ-007 In REQ, dmem_req_out SHALL be 1, with all bus outputs driven from the captured registers and held stable until dmem_gnt_in.
REQ-008 For a write in REQ with dmem_gnt_in:
- the next state SHALL be IDLE;
- if dmem_err_in is high, bus_err_out SHALL pulse 1 cycle.
REQ-009 For a read in REQ with dmem_gnt_in, the next state SHALL be RWAIT and dmem_req_out SHALL drop.
REQ-010 In RWAIT, on dmem_rvalid_in:
- load_data_out SHALL be registered;
- load_valid_out SHALL pulse 1 cycle, or bus_err_out SHALL pulse instead if dmem_err_in is high;
- the next state SHALL be IDLE.
REQ-011 An 8-bit timeout counter SHALL clear on entry to REQ and increment in REQ and RWAIT.
REQ-012 When the timeout counter reaches TIMEOUT_CYCLES, bus_err_out SHALL pulse, dmem_req_out SHALL drop, and the state SHALL go to IDLE.
REQ-013 dmem_wmask_out SHALL be:
- byte: 0001 << addr[1:0];
- half: 0011 << {addr[1],0};
- word: 1111;
- read: 0000.
REQ-014 dmem_wdata_out SHALL be:
- byte: data[7:0] replicated x4;
- half: data[15:0] replicated x2;
- word: data unchanged.
REQ-015 Load alignment SHALL select the byte or half lane from the captured addr[1:0], then zero- or sign-extend to 32 bits per load_unsigned; word loads SHALL pass unchanged.
REQ-016 The block SHALL NOT check misalignment (handled upstream); for word accesses addr[1:0] SHALL be ignored, and for half accesses addr[0] SHALL be ignored.
REQ-017 load_valid_out and bus_err_out SHALL never both be high in the same cycle.
REQ-018 A request in the cycle a completion strobe fires SHALL be accepted only once the state is IDLE; back-to-back throughput SHALL be 1 access per 2 cycles at minimum.

Reset
REQ-019 Reset SHALL asynchronously force state IDLE and counter 0.
REQ-020 Reset SHALL force all outputs to 0, including dmem_req_out, which SHALL drop immediately mid-transaction.
REQ-021 A completion arriving after reset SHALL be ignored.

Structure
REQ-022 The state encodings, size encodings (SIZE_B/H/W) and the default TIMEOUT_CYCLES SHALL live in the shared msrv32 package.
REQ-023 Lane select and extension SHALL be the sub-module msrv32_load_align, which is combinational.

Verification
REQ-024 sb: addr 0x1003, data 0x000000A5 -> dmem_addr 0x1000, mask 1000, wdata 0xA5A5A5A5; with gnt in 2nd REQ cycle, stall high 3 cycles.
REQ-025 lh: addr 0x2002, rdata 0x8001xxxx, unsigned 0 -> load_data 0xFFFF8001 and load_valid pulse; with unsigned 1 -> 0x00008001.
REQ-026 Simultaneous rd+wr requests -> a single write transaction with dmem_we 1.
REQ-027 TIMEOUT_CYCLES=4 with gnt held 0 -> bus_err pulse after 4 REQ cycles, back to IDLE, no load_valid.
REQ-028 Reset asserted in RWAIT, then rvalid -> no load_valid, all outputs 0, and the next request is served normally.
REQ-029 lw with rvalid and err -> bus_err pulse, load_valid stays 0.
